// File: rtl/im2_int_controller_pkg.sv
// Shared constants, RETI FSM state type and vector helper for the IM2 interrupt controller.
package im2_int_controller_pkg;

  localparam int INTC_SRC_FRAME = 0;
  localparam int INTC_SRC_LINE  = 1;
  localparam int INTC_SRC_TIMER = 2;
  localparam int INTC_SRC_EXT   = 3;

  localparam logic [7:0] OPC_ED    = 8'hED;
  localparam logic [7:0] OPC_RETI2 = 8'h4D;

  typedef enum logic {RETI_IDLE, RETI_GOT_ED} reti_state_t;

  // IM2 vector: table base in the top five bits, source index in bits [2:1], always even.
  function automatic logic [7:0] make_vector(input logic [4:0] base_hi, input logic [1:0] idx);
    return {base_hi, idx, 1'b0};
  endfunction

endpackage

// File: rtl/im2_int_controller_reti_detector.sv
// Watches M1 opcode fetches for the ED 4D (RETI) sequence and pulses reti_stb once per RETI.
module reti_detector
  import im2_int_controller_pkg::*;
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       m1,
  input  logic       mreq,
  input  logic       rd,
  input  logic       iorq,
  input  logic [7:0] d_in,
  output logic       reti_stb
);

  reti_state_t state;
  logic        fetch;
  logic        fetch_d;
  logic        sample;

  assign fetch  = m1 & mreq & rd & ~iorq;
  assign sample = fetch_d & ~fetch;

  // Opcode byte is taken at the end of each fetch, while the bus still holds it.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state    <= RETI_IDLE;
      fetch_d  <= 1'b0;
      reti_stb <= 1'b0;
    end else begin
      fetch_d  <= fetch;
      reti_stb <= 1'b0;
      if (sample) begin
        case (state)
          RETI_IDLE: begin
            state <= (d_in == OPC_ED) ? RETI_GOT_ED : RETI_IDLE;
          end
          RETI_GOT_ED: begin
            if (d_in == OPC_RETI2) begin
              reti_stb <= 1'b1;
              state    <= RETI_IDLE;
            end else if (d_in == OPC_ED) begin
              state <= RETI_GOT_ED;
            end else begin
              state <= RETI_IDLE;
            end
          end
          default: state <= RETI_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/im2_int_controller.sv
// Prioritised IM2 interrupt controller: pending/expiry tracking, INT generation, vector supply.
// Define INTC_RETI_EN to add in-service tracking released by RETI (priority nesting).
module im2_int_controller
  import im2_int_controller_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int INT_LEN = 32
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic             clkcpu_ck,
  input  logic             m1,
  input  logic             iorq,
  input  logic             mreq,
  input  logic             rd,
  input  logic [7:0]       d_in,
  input  logic [N_SRC-1:0] int_req,
  input  logic [N_SRC-1:0] int_mask,
  input  logic [7:0]       vector_base,
  output logic             n_int,
  output logic [7:0]       d_out,
  output logic             d_oe,
  output logic [1:0]       ack_src,
  output logic             ack_stb
);

  logic             inta;
  logic             inta_d;
  logic             ack_edge;
  logic             ack_valid;
  logic             any_elig;
  logic             expire;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] ins;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] win_oh;
  logic [N_SRC-1:0] clr;
  logic [1:0]       win;
  logic [4:0]       exp_cnt;

  assign inta      = m1 & iorq;
  assign ack_edge  = inta & ~inta_d;
  assign any_elig  = |elig;
  assign ack_valid = ack_edge & any_elig;
  assign expire    = clkcpu_ck & any_elig & (exp_cnt == 5'(INT_LEN - 1));

  // An in-service source blocks itself and every lower-priority source.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    elig    = '0;
    win     = 2'(N_SRC - 1);
    for (int i = 0; i < N_SRC; i++) begin
      blocked = blocked | ins[i];
      elig[i] = pend[i] & int_mask[i] & ~blocked;
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win = elig[i] ? 2'(i) : win;
    end
  end

  // One-hot form of the winner, used for pend clear and ins set.
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      win_oh[i] = (win == 2'(i));
    end
  end

  // A new request in the same cycle as its clear survives.
  assign clr       = ({N_SRC{ack_valid}} & win_oh) | ({N_SRC{expire}} & elig);
  assign pend_next = (pend & ~clr) | int_req;

  // Pending state, expiry timer and all CPU-facing outputs.
  always_ff @(posedge clk28) begin
    if (rst) begin
      inta_d  <= 1'b0;
      pend    <= '0;
      exp_cnt <= 5'd0;
      n_int   <= 1'b1;
      d_out   <= 8'h00;
      d_oe    <= 1'b0;
      ack_src <= 2'd0;
      ack_stb <= 1'b0;
    end else begin
      inta_d  <= inta;
      pend    <= pend_next;
      d_oe    <= inta;
      ack_stb <= ack_valid;
      if (ack_edge) begin
        d_out <= make_vector(vector_base[7:3], win);
      end
      if (ack_valid) begin
        ack_src <= win;
      end
      if (clkcpu_ck) begin
        n_int <= ~any_elig;
      end
      if (!any_elig || ack_valid || expire) begin
        exp_cnt <= 5'd0;
      end else if (clkcpu_ck) begin
        exp_cnt <= exp_cnt + 5'd1;
      end
    end
  end

`ifdef INTC_RETI_EN
  logic             reti_stb;
  logic [N_SRC-1:0] ins_clr;

  reti_detector u_reti (
    .clk28    (clk28),
    .rst      (rst),
    .m1       (m1),
    .mreq     (mreq),
    .rd       (rd),
    .iorq     (iorq),
    .d_in     (d_in),
    .reti_stb (reti_stb)
  );

  // RETI releases the highest-priority in-service source only.
  always_comb begin
    ins_clr = '0;
    if (reti_stb) begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        ins_clr[i] = ins[i] & ~found;
        found      = found | ins[i];
      end
    end else begin
      ins_clr = '0;
    end
  end

  // In-service register: set by acknowledge, cleared by RETI; masking leaves it alone.
  always_ff @(posedge clk28) begin
    if (rst) begin
      ins <= '0;
    end else begin
      ins <= (ins & ~ins_clr) | ({N_SRC{ack_valid}} & win_oh);
    end
  end
`else
  logic unused_fetch_bus;
  assign ins              = '0;
  assign unused_fetch_bus = ^{mreq, rd, d_in};
`endif

  logic unused_base_low;
  assign unused_base_low = ^vector_base[2:0];

endmodule

// File: tb/tb_im2_int_controller.sv
// Directed scoreboard bench for im2_int_controller; works with or without INTC_RETI_EN.
module tb_im2_int_controller;
  import im2_int_controller_pkg::*;

  localparam int N_SRC = 4;

  logic             clk28 = 1'b0;
  logic             rst = 1'b1;
  logic             clkcpu_ck = 1'b0;
  logic             m1 = 1'b0;
  logic             iorq = 1'b0;
  logic             mreq = 1'b0;
  logic             rd = 1'b0;
  logic [7:0]       d_in = 8'h00;
  logic [N_SRC-1:0] int_req = '0;
  logic [N_SRC-1:0] int_mask = '0;
  logic [7:0]       vector_base = 8'h00;
  logic             n_int;
  logic [7:0]       d_out;
  logic             d_oe;
  logic [1:0]       ack_src;
  logic             ack_stb;

  typedef struct {
    logic       stb;
    logic [1:0] src;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nstb = 0;

  im2_int_controller #(.N_SRC(N_SRC), .INT_LEN(32)) dut (
    .clk28       (clk28),
    .rst         (rst),
    .clkcpu_ck   (clkcpu_ck),
    .m1          (m1),
    .iorq        (iorq),
    .mreq        (mreq),
    .rd          (rd),
    .d_in        (d_in),
    .int_req     (int_req),
    .int_mask    (int_mask),
    .vector_base (vector_base),
    .n_int       (n_int),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .ack_src     (ack_src),
    .ack_stb     (ack_stb)
  );

  initial forever #5 clk28 = ~clk28;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clk28 cycle; outputs are read at the falling edge, CPU strobe every 4th cycle.
  task automatic step();
    @(posedge clk28);
    if (clkcpu_ck) nstb++;
    @(negedge clk28);
    cyc++;
    clkcpu_ck = ((cyc % 4) == 0);
  endtask

  task automatic to_strobe();
    int n0;
    int k;
    n0 = nstb;
    k  = 0;
    while (nstb == n0 && k < 16) begin
      step();
      k++;
    end
    chk("strobe_seen", 32'(nstb != n0), 32'd1);
  endtask

  task automatic pulse(input logic [N_SRC-1:0] r);
    int_req = r;
    step();
    int_req = '0;
  endtask

  task automatic do_inta(input logic stb, input logic [1:0] src, input logic [7:0] vec);
    exp_t e;
    e.stb = stb;
    e.src = src;
    e.vec = vec;
    exp_q.push_back(e);
    m1   = 1'b1;
    iorq = 1'b1;
    step();
    e = exp_q.pop_front();
    chk("ack_stb", 32'(ack_stb), 32'(e.stb));
    chk("ack_src", 32'(ack_src), 32'(e.src));
    chk("d_out", 32'(d_out), 32'(e.vec));
    chk("d_oe_on", 32'(d_oe), 32'd1);
    step();
    chk("ack_stb_pulse", 32'(ack_stb), 32'd0);
    chk("d_out_hold", 32'(d_out), 32'(e.vec));
    m1   = 1'b0;
    iorq = 1'b0;
    step();
    chk("d_oe_off", 32'(d_oe), 32'd0);
  endtask

  task automatic fetch(input logic [7:0] b);
    m1   = 1'b1;
    mreq = 1'b1;
    rd   = 1'b1;
    d_in = b;
    step();
    step();
    m1   = 1'b0;
    mreq = 1'b0;
    rd   = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_n_int", 32'(n_int), 32'd1);
    chk("rst_d_out", 32'(d_out), 32'h00);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    chk("rst_ack_src", 32'(ack_src), 32'd0);
    chk("rst_ack_stb", 32'(ack_stb), 32'd0);
    rst         = 1'b0;
    int_mask    = 4'b1111;
    vector_base = 8'hF8;
    step();

    // Single request from the frame source
    pulse(4'b0001 << INTC_SRC_FRAME);
    to_strobe();
    chk("single_n_int_low", 32'(n_int), 32'd0);
    do_inta(1'b1, 2'd0, 8'hF8);
    to_strobe();
    chk("single_n_int_high", 32'(n_int), 32'd1);
`ifdef INTC_RETI_EN
    fetch(8'hED);
    fetch(8'h4D);
`endif

    // Priority: line beats timer
    pulse(4'b0110);
    to_strobe();
    chk("prio_n_int_low", 32'(n_int), 32'd0);
    do_inta(1'b1, 2'd1, 8'hFA);
`ifdef INTC_RETI_EN
    to_strobe();
    chk("prio_nested_blocked", 32'(n_int), 32'd1);
    fetch(8'hED);
    fetch(8'h4D);
    to_strobe();
    chk("prio_after_reti", 32'(n_int), 32'd0);
    do_inta(1'b1, 2'd2, 8'hFC);
    fetch(8'hED);
    fetch(8'h4D);
`else
    to_strobe();
    chk("prio_second_low", 32'(n_int), 32'd0);
    do_inta(1'b1, 2'd2, 8'hFC);
`endif
    to_strobe();
    chk("prio_idle", 32'(n_int), 32'd1);

    // Expiry: INT held low for exactly 32 CPU clocks, then the request is gone
    pulse(4'b1000);
    to_strobe();
    chk("exp_n_int_low", 32'(n_int), 32'd0);
    for (int s = 0; s < 31; s++) to_strobe();
    chk("exp_still_low_32", 32'(n_int), 32'd0);
    to_strobe();
    chk("exp_high_after", 32'(n_int), 32'd1);
    do_inta(1'b0, 2'd2, 8'hFE);

`ifdef INTC_RETI_EN
    // RETI decode: ED,00,4D must not release, ED,ED,4D must
    pulse(4'b0001);
    to_strobe();
    do_inta(1'b1, 2'd0, 8'hF8);
    pulse(4'b0010);
    to_strobe();
    chk("reti_blocked", 32'(n_int), 32'd1);
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    to_strobe();
    chk("reti_broken_seq", 32'(n_int), 32'd1);
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    to_strobe();
    chk("reti_double_ed", 32'(n_int), 32'd0);
    do_inta(1'b1, 2'd1, 8'hFA);
    fetch(8'hED);
    fetch(8'h4D);
`endif

    // Masking holds INT off until the source is re-enabled
    int_mask = 4'b1110;
    pulse(4'b0001);
    to_strobe();
    chk("mask_off_1", 32'(n_int), 32'd1);
    to_strobe();
    to_strobe();
    chk("mask_off_3", 32'(n_int), 32'd1);
    int_mask = 4'b1111;
    to_strobe();
    to_strobe();
    chk("mask_on", 32'(n_int), 32'd0);

    // Reset in the middle of an acknowledge
    exp_q.push_back('{1'b1, 2'd0, 8'hF8});
    m1   = 1'b1;
    iorq = 1'b1;
    step();
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rstack_stb", 32'(ack_stb), 32'(e.stb));
      chk("rstack_d_out", 32'(d_out), 32'(e.vec));
      chk("rstack_d_oe", 32'(d_oe), 32'd1);
    end
    rst = 1'b1;
    step();
    chk("rstack_d_oe_clr", 32'(d_oe), 32'd0);
    chk("rstack_n_int", 32'(n_int), 32'd1);
    chk("rstack_d_out_clr", 32'(d_out), 32'h00);
    m1   = 1'b0;
    iorq = 1'b0;
    step();
    rst = 1'b0;
    to_strobe();
    to_strobe();
    chk("rstack_no_pend", 32'(n_int), 32'd1);
    pulse(4'b0010);
    to_strobe();
    to_strobe();
    chk("rstack_no_ins", 32'(n_int), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
